// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the instruction/data SRAM arbiter.
// Requester IDs, grant FSM encoding, access-size codes, request bundle.
package sram_arb_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: sram-like request/response channel.
// master issues requests, slave answers with addr_ok/data_ok/rdata.
interface sram_arbiter_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/arb_order_fifo.sv
// arb_order_fifo: 1-bit requester-ID FIFO that records the order of
// accepted requests so responses can be routed back in order.
module arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head  = ids[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // pointer/occupancy update; push and pop together keep count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ids    <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= inc(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges inst/data sram-like masters onto one memory port.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties (else data wins).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic reset,
  sram_arbiter_if.slave  inst_sram,
  sram_arbiter_if.slave  data_sram,
  sram_arbiter_if.master mem
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       win;
  logic       sel;
  logic       fwd;
  logic       push;
  logic       pop;
  logic       head;
  logic       full;
  logic       empty;
  sram_req_t  ireq_f;
  sram_req_t  dreq_f;
  sram_req_t  fwd_f;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last;

  // remember who won the most recent accepted request
  always_ff @(posedge clk) begin
    if (reset)
      last <= REQ_DATA;
    else if (push)
      last <= sel;
  end

  assign win = (inst_sram.req && data_sram.req) ? ~last
             : (data_sram.req ? REQ_DATA : REQ_INST);
`else
  assign win = data_sram.req ? REQ_DATA : REQ_INST;
`endif

  // grant state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // pick forwarded requester; lock it until the port accepts
  always_comb begin
    state_nxt = state;
    sel       = win;
    fwd       = 1'b0;
    unique case (state)
      IDLE: begin
        fwd = !full && (inst_sram.req || data_sram.req);
        if (fwd && !mem.addr_ok)
          state_nxt = (win == REQ_DATA) ? GNT_DATA : GNT_INST;
      end
      GNT_INST: begin
        sel = REQ_INST;
        fwd = inst_sram.req;
        if (fwd && mem.addr_ok)
          state_nxt = IDLE;
      end
      GNT_DATA: begin
        sel = REQ_DATA;
        fwd = data_sram.req;
        if (fwd && mem.addr_ok)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset)
      fwd = 1'b0;
  end

  assign ireq_f = '{wr: inst_sram.wr, size: inst_sram.size,
                    wstrb: inst_sram.wstrb, addr: inst_sram.addr,
                    wdata: inst_sram.wdata};
  assign dreq_f = '{wr: data_sram.wr, size: data_sram.size,
                    wstrb: data_sram.wstrb, addr: data_sram.addr,
                    wdata: data_sram.wdata};
  assign fwd_f  = (sel == REQ_DATA) ? dreq_f : ireq_f;

  assign mem.req   = fwd;
  assign mem.wr    = fwd_f.wr;
  assign mem.size  = fwd_f.size;
  assign mem.wstrb = fwd_f.wstrb;
  assign mem.addr  = fwd_f.addr;
  assign mem.wdata = fwd_f.wdata;

  assign push = fwd && mem.addr_ok;
  assign pop  = mem.data_ok && !empty && !reset;

  assign inst_sram.addr_ok = push && (sel == REQ_INST);
  assign data_sram.addr_ok = push && (sel == REQ_DATA);
  assign inst_sram.data_ok = pop && (head == REQ_INST);
  assign data_sram.data_ok = pop && (head == REQ_DATA);
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  arb_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // flag stray responses and requesters abandoning a locked grant
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(mem.data_ok && empty))
        else $warning("sram_arbiter: response with nothing outstanding");
      assert (!(state != IDLE && !fwd))
        else $warning("sram_arbiter: granted requester dropped req");
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, max accepted-but-unanswered shared-port requests; power of two, >=1.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 inst_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  instruction requester, sram-like request channel.
REQ-005 inst_sram_{addr_ok,data_ok}  out  1/1  instruction requester handshakes; inst_sram_rdata  out  32  read data.
REQ-006 data_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  data requester, sram-like request channel.
REQ-007 data_sram_{addr_ok,data_ok}  out  1/1; data_sram_rdata  out  32.
REQ-008 mem_{req,wr,size,wstrb,addr,wdata}  out  1/1/2/4/32/32  shared memory port request.
REQ-009 mem_{addr_ok,data_ok}  in  1/1; mem_rdata  in  32  shared port responses, returned in request order.

Function
REQ-010 Grant FSM states IDLE, GNT_INST, GNT_DATA; reset state IDLE.
REQ-011 IDLE: if order FIFO not full and any req high, winner chosen combinationally, its request fields driven onto mem_* same cycle (zero-cycle latency).
REQ-012 IDLE, winner forwarded, mem_addr_ok=0 -> GNT_INST/GNT_DATA per winner; request held locked to that requester.
REQ-013 GNT_x: forward only requester x; mem_addr_ok=1 -> IDLE; other requester never sees addr_ok.
REQ-014 Any state, mem_req=1 and mem_addr_ok=1 -> addr_ok to granted requester only, same cycle; winner ID pushed into order FIFO.
REQ-015 Order FIFO full -> mem_req=0 in IDLE; pending requests wait, no addr_ok.
REQ-016 mem_data_ok=1 -> pop FIFO head; data_ok asserted same cycle only to head ID's requester; mem_rdata broadcast to both rdata outputs.
REQ-017 Writes also tracked; every accepted request yields exactly one routed data_ok.
REQ-018 Simultaneous push and pop: both performed, occupancy unchanged; legal when full (pop frees slot next cycle, not same cycle).
REQ-019 mem_data_ok with FIFO empty: ignored, no data_ok routed; simulation assertion fires.
REQ-020 Occupancy counter width clog2(MAX_OUTSTANDING)+1; read/write pointers wrap modulo MAX_OUTSTANDING.
REQ-021 No grant switch while a forwarded request is un-acknowledged, even if requester drops req (protocol violation; assertion).

Reset
REQ-022 reset: FSM IDLE, FIFO empty, pointers/count 0, last-grant register = DATA.
REQ-023 While reset high: mem_req, inst/data addr_ok, inst/data data_ok all 0.
REQ-024 Reset mid-operation discards outstanding IDs; responses arriving after reset are treated per REQ-019.

Configuration
REQ-025 Macro SRAM_ARB_ROUND_ROBIN_EN defined: both reqs in IDLE -> grant requester not granted last; last-grant updated on each addr_ok handshake.
REQ-026 Macro undefined: fixed priority, data requester always wins ties; last-grant register absent.

Structure
REQ-027 Package sram_arb_pkg: requester ID constants (REQ_INST=0, REQ_DATA=1), FSM state encoding, size encodings (byte=0, half=1, word=2).
REQ-028 One sub-module arb_order_fifo: ID-wide (1-bit) synchronous FIFO, depth MAX_OUTSTANDING, push/pop/full/empty/head outputs.

Verification
REQ-029 Inst-only read 0x1c000000, addr_ok cycle 1, data_ok cycle 3 rdata 0x02800000 -> inst addr_ok cycle 1, inst data_ok cycle 3 with 0x02800000, data side silent.
REQ-030 Both req same cycle, no RR macro -> data granted, addr 0x00001000 on mem_addr; inst granted after data addr_ok; responses routed data then inst.
REQ-031 Same with SRAM_ARB_ROUND_ROBIN_EN, three consecutive tie cycles -> grants inst, data, inst.
REQ-032 mem_addr_ok held low 4 cycles while data req rises during GNT_INST -> mem_addr stays inst address; no data addr_ok until inst accepted.
REQ-033 MAX_OUTSTANDING=2, two accepted, no data_ok -> third req sees mem_req=0; data_ok pop in cycle N -> third forwarded cycle N+1.
REQ-034 Reset pulse with one outstanding, then stray mem_data_ok -> no requester data_ok, FIFO empty, assertion logged.
